// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory and decode-side signals of the fetch stage.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word fetches to a 1-cycle-latency memory, buffers
// returned words with their PC and hands them to decode; a redirect flushes everything.
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [31:0]   r_fetchPc;
    logic [31:0]   r_respPc;
    logic          r_respPending;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [31:0]   r_bufInstr [DEPTH];
    logic [31:0]   r_bufPc    [DEPTH];

    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [CW:0]   w_occupancy;
    logic          w_unusedPcBits;

    assign w_pop          = (r_count != '0) && bus.instr_ready;
    assign w_push         = r_respPending && !bus.redirect_valid;
    assign w_occupancy    = {1'b0, r_count} + (CW+1)'(r_respPending) - (CW+1)'(w_pop);
    assign w_unusedPcBits = ^bus.redirect_pc[1:0];

    assign bus.imem_req    = w_issue;
    assign bus.imem_addr   = r_fetchPc;
    assign bus.instr_valid = (r_count != '0);
    assign bus.instr       = r_bufInstr[r_rdPtr];
    assign bus.instr_pc    = r_bufPc[r_rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_stateNext;
    end

    // A request goes out only if the word it returns is guaranteed a free buffer slot.
    always_comb begin
        w_stateNext = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE:    w_stateNext = FETCH;
            FETCH:   w_issue = !bus.redirect_valid && (w_occupancy < (CW+1)'(DEPTH));
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetchPc     <= RESET_PC;
            r_respPc      <= 32'h0;
            r_respPending <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_fetchPc     <= {bus.redirect_pc[31:2], 2'b00};
            r_respPending <= 1'b0;
        end else begin
            r_respPending <= w_issue;
            if (w_issue) begin
                r_respPc  <= r_fetchPc;
                r_fetchPc <= r_fetchPc + 32'd4;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_bufInstr[i] <= 32'h0;
                r_bufPc[i]    <= 32'h0;
            end
        end else if (bus.redirect_valid) begin
            r_count <= '0;
            r_rdPtr <= '0;
            r_wrPtr <= '0;
        end else begin
            if (w_push) begin
                r_bufInstr[r_wrPtr] <= bus.imem_rdata;
                r_bufPc[r_wrPtr]    <= r_respPc;
                r_wrPtr             <= r_wrPtr + 1'b1;
            end
            if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance from PC 0 and one from near the top of
// the address space; memory returns addr+100 one cycle after each request.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if busA ();
    fetch_unit_if busB ();

    fetch_unit #(.DEPTH(2), .RESET_PC(32'h0)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA.master)
    );

    fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB.master)
    );

    // Synchronous instruction memory: word for addr is addr+100, one cycle later.
    always @(posedge clk) begin
        if (busA.imem_req) busA.imem_rdata <= busA.imem_addr + 32'd100;
        if (busB.imem_req) busB.imem_rdata <= busB.imem_addr + 32'd100;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
        busA.instr_ready    = ready;
        busA.redirect_valid = redir;
        busA.redirect_pc    = rpc;
    endtask

    task automatic step(input logic ready, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        applyStimulus(ready, redir, rpc);
        #1;
    endtask

    task automatic resetDut(input logic ready);
        rst_n = 1'b0;
        applyStimulus(ready, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n               = 1'b0;
        busB.instr_ready    = 1'b1;
        busB.redirect_valid = 1'b0;
        busB.redirect_pc    = 32'h0;
        applyStimulus(1'b1, 1'b0, 32'h0);

        @(negedge clk);
        #1;
        checkOutput("rst_req",   {31'h0, busA.imem_req},    32'h0);
        checkOutput("rst_addr",  busA.imem_addr,            32'h0);
        checkOutput("rst_valid", {31'h0, busA.instr_valid}, 32'h0);
        checkOutput("rst_instr", busA.instr,                32'h0);
        checkOutput("rst_pc",    busA.instr_pc,             32'h0);
        checkOutput("rst_addrB", busB.imem_addr,            32'hFFFF_FFF8);

        // Streaming with ready held high; instance B covers the 32-bit PC wrap.
        resetDut(1'b1);
        step(1'b1, 1'b0, 32'h0);
        checkOutput("t1_c1_req",  {31'h0, busA.imem_req},    32'h1);
        checkOutput("t1_c1_addr", busA.imem_addr,            32'h0);
        step(1'b1, 1'b0, 32'h0);
        checkOutput("t1_c2_addr",  busA.imem_addr,            32'h4);
        checkOutput("t1_c2_valid", {31'h0, busA.instr_valid}, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        checkOutput("t1_c3_valid", {31'h0, busA.instr_valid}, 32'h1);
        checkOutput("t1_c3_pc",    busA.instr_pc,             32'h0);
        checkOutput("t1_c3_instr", busA.instr,                32'h64);
        checkOutput("t5_pc0",      busB.instr_pc,             32'hFFFF_FFF8);
        checkOutput("t5_instr0",   busB.instr,                32'h0000_005C);
        step(1'b1, 1'b0, 32'h0);
        checkOutput("t1_c4_pc",    busA.instr_pc,             32'h4);
        checkOutput("t1_c4_instr", busA.instr,                32'h68);
        checkOutput("t5_pc1",      busB.instr_pc,             32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        checkOutput("t1_c5_pc",    busA.instr_pc,             32'h8);
        checkOutput("t5_pc2",      busB.instr_pc,             32'h0);
        checkOutput("t5_instr2",   busB.instr,                32'h64);
        step(1'b1, 1'b0, 32'h0);
        checkOutput("t1_c6_pc",    busA.instr_pc,             32'hC);
        checkOutput("t1_c6_valid", {31'h0, busA.instr_valid}, 32'h1);
        checkOutput("t5_pc3",      busB.instr_pc,             32'h4);

        // Backpressure from reset: only two requests fit a two-entry buffer.
        resetDut(1'b0);
        step(1'b0, 1'b0, 32'h0);
        checkOutput("t2_c1_addr", busA.imem_addr,         32'h0);
        checkOutput("t2_c1_req",  {31'h0, busA.imem_req}, 32'h1);
        step(1'b0, 1'b0, 32'h0);
        checkOutput("t2_c2_addr", busA.imem_addr,         32'h4);
        checkOutput("t2_c2_req",  {31'h0, busA.imem_req}, 32'h1);
        step(1'b0, 1'b0, 32'h0);
        checkOutput("t2_c3_req",  {31'h0, busA.imem_req}, 32'h0);
        checkOutput("t2_c3_pc",   busA.instr_pc,          32'h0);
        step(1'b0, 1'b0, 32'h0);
        checkOutput("t2_c4_req",   {31'h0, busA.imem_req}, 32'h0);
        checkOutput("t2_c4_pc",    busA.instr_pc,          32'h0);
        checkOutput("t2_c4_instr", busA.instr,             32'h64);
        step(1'b1, 1'b0, 32'h0);
        checkOutput("t2_pop_req",  {31'h0, busA.imem_req}, 32'h1);
        checkOutput("t2_pop_addr", busA.imem_addr,         32'h8);
        checkOutput("t2_pop_pc",   busA.instr_pc,          32'h0);
        step(1'b1, 1'b0, 32'h0);
        checkOutput("t2_c6_pc",   busA.instr_pc,  32'h4);
        checkOutput("t2_c6_addr", busA.imem_addr, 32'hC);
        step(1'b0, 1'b0, 32'h0);
        checkOutput("t2_c7_pc",  busA.instr_pc,          32'h8);
        checkOutput("t2_c7_req", {31'h0, busA.imem_req}, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        checkOutput("t2_c8_pc",   busA.instr_pc,  32'h8);
        checkOutput("t2_c8_addr", busA.imem_addr, 32'h10);

        // Redirect while pc 12 is buffered and the word for pc 16 is arriving.
        step(1'b0, 1'b1, 32'h100);
        checkOutput("t3_r_pc",  busA.instr_pc,          32'hC);
        checkOutput("t3_r_req", {31'h0, busA.imem_req}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        checkOutput("t3_r1_valid", {31'h0, busA.instr_valid}, 32'h0);
        checkOutput("t3_r1_req",   {31'h0, busA.imem_req},    32'h1);
        checkOutput("t3_r1_addr",  busA.imem_addr,            32'h100);
        step(1'b1, 1'b0, 32'h0);
        checkOutput("t3_r2_valid", {31'h0, busA.instr_valid}, 32'h0);

        // Redirect to an unaligned target in the same cycle the head is popped.
        step(1'b1, 1'b1, 32'h203);
        checkOutput("t3_r3_valid", {31'h0, busA.instr_valid}, 32'h1);
        checkOutput("t3_r3_pc",    busA.instr_pc,             32'h100);
        checkOutput("t3_r3_instr", busA.instr,                32'h164);
        checkOutput("t4_r_req",    {31'h0, busA.imem_req},    32'h0);
        step(1'b1, 1'b0, 32'h0);
        checkOutput("t4_r1_valid", {31'h0, busA.instr_valid}, 32'h0);
        checkOutput("t4_r1_addr",  busA.imem_addr,            32'h200);
        checkOutput("t4_r1_req",   {31'h0, busA.imem_req},    32'h1);
        step(1'b1, 1'b0, 32'h0);
        checkOutput("t4_r2_valid", {31'h0, busA.instr_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        checkOutput("t4_r3_pc",    busA.instr_pc, 32'h200);
        checkOutput("t4_r3_instr", busA.instr,    32'h264);
        step(1'b0, 1'b0, 32'h0);
        checkOutput("t4_full_pc",  busA.instr_pc,          32'h200);
        checkOutput("t4_full_req", {31'h0, busA.imem_req}, 32'h0);

        // Asynchronous reset with a full buffer, then restart from RESET_PC.
        rst_n = 1'b0;
        #1;
        checkOutput("t6_valid", {31'h0, busA.instr_valid}, 32'h0);
        checkOutput("t6_instr", busA.instr,                32'h0);
        checkOutput("t6_pc",    busA.instr_pc,             32'h0);
        checkOutput("t6_addr",  busA.imem_addr,            32'h0);
        checkOutput("t6_req",   {31'h0, busA.imem_req},    32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 32'h0);
        checkOutput("t6_c1_addr", busA.imem_addr,         32'h0);
        checkOutput("t6_c1_req",  {31'h0, busA.imem_req}, 32'h1);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        checkOutput("t6_c3_valid", {31'h0, busA.instr_valid}, 32'h1);
        checkOutput("t6_c3_pc",    busA.instr_pc,             32'h0);
        checkOutput("t6_c3_instr", busA.instr,                32'h64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
